// File: rtl/mem_resp_pkg.sv
// Shared types and region decode for the 6502 bus responder.
package mem_pkg;

   localparam int WAIT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      DONE
   } state_t;

   // IO page wins over zero page, so IO_PAGE=8'h00 turns page 0 into IO.
   function automatic logic [WAIT_W-1:0] page_wait(
      input logic [7:0]        page,
      input logic [WAIT_W-1:0] zp_wait,
      input logic [WAIT_W-1:0] mem_wait,
      input logic [7:0]        io_page,
      input logic [WAIT_W-1:0] io_wait
   );
      if (page == io_page)
         return io_wait;
      else if (page == 8'h00)
         return zp_wait;
      else
         return mem_wait;
   endfunction

endpackage

// File: rtl/mem_resp_wait_ctr.sv
// Loadable down-counter with zero flag used to time bus wait states.
module mem_wait_ctr
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   output logic [WAIT_W-1:0] count,
   output logic              zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (dec)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_resp.sv
// CPU bus responder: region-dependent wait states in front of a sync SRAM.
module mem_resp
   import mem_pkg::*;
#(
   parameter logic [WAIT_W-1:0] ZP_WAIT  = 4'd0,
   parameter logic [WAIT_W-1:0] MEM_WAIT = 4'd2,
   parameter logic [7:0]        IO_PAGE  = 8'hD0,
   parameter logic [WAIT_W-1:0] IO_WAIT  = 4'd3
) (
   input  logic        CLK,
   input  logic        nRES,
   input  logic        VLD,
   input  logic        RW,
   input  logic [15:0] A,
   input  logic [7:0]  DO,
   output logic [7:0]  DI,
   output logic        RDY,
   output logic [15:0] M_A,
   output logic        M_RE,
   output logic        M_WE,
   output logic [7:0]  M_WD,
   input  logic [7:0]  M_RD
);

   state_t            state;
   logic              rw_q;
   logic [15:0]       a_q;
   logic [7:0]        do_q;
   logic [7:0]        di_q;
   logic              rdy_q;
   logic              re_q;
   logic              we_q;
   logic [WAIT_W-1:0] req_wait;
   logic [WAIT_W-1:0] count;
   logic              zero;
   logic              accept;

   always_comb begin
      req_wait = page_wait(A[15:8], ZP_WAIT, MEM_WAIT, IO_PAGE, IO_WAIT);
      accept   = (state == IDLE) && VLD;
   end

   mem_wait_ctr u_wait_ctr (
      .clk      (CLK),
      .rst_n    (nRES),
      .load     (accept),
      .load_val (req_wait),
      .dec      ((state == WAIT) && !zero),
      .count    (count),
      .zero     (zero)
   );

   // Strobes are registered on entry to ACCESS/DONE so they mirror the state exactly.
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         state <= IDLE;
         rw_q  <= 1'b0;
         a_q   <= '0;
         do_q  <= '0;
         di_q  <= '0;
         rdy_q <= 1'b0;
         re_q  <= 1'b0;
         we_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (VLD) begin
                  rw_q <= RW;
                  a_q  <= A;
                  do_q <= DO;
                  if (req_wait == '0) begin
                     state <= ACCESS;
                     re_q  <= RW;
                     we_q  <= !RW;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (count == WAIT_W'(1)) begin
                  state <= ACCESS;
                  re_q  <= rw_q;
                  we_q  <= !rw_q;
               end
            end
            ACCESS: begin
               state <= DONE;
               re_q  <= 1'b0;
               we_q  <= 1'b0;
               rdy_q <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               rdy_q <= 1'b0;
               if (rw_q)
                  di_q <= M_RD;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign RDY  = rdy_q;
   assign M_RE = re_q;
   assign M_WE = we_q;
   assign M_A  = a_q;
   assign M_WD = do_q;
   assign DI   = ((state == DONE) && rw_q) ? M_RD : di_q;

endmodule
